ram_clear_ctrl: RTL and testbench
=================================

RAM_CLEAR_CTRL -- requirements
Module: ram_clear_ctrl

Interface
REQ-001 SHALL have parameter SD_WORDS, default 33554432, SDRAM 16-bit words to clear (1..2^25).
REQ-002 SHALL have parameter DDR_WORDS, default 268435456, DDR3 64-bit words to clear (1..2^28).
REQ-003 SHALL have parameter WE_GAP, default 32, minimum cycles between SDRAM write strobes (2..256).
REQ-004 SHALL have ports: clk_sys in 1 system clock; RESET in 1 reset, synchronous, active-low.
REQ-005 SHALL have ports: start in 1 begin-clear pulse; abort in 1 stop request.
REQ-006 SHALL have ports: sd_we out 1 SDRAM write strobe; sd_addr out 25 SDRAM word address; sd_din out 16 SDRAM write data.
REQ-007 SHALL have ports: ddr_we out 1 DDR write request; ddr_addr out 28 DDR word address; ddr_din out 64 DDR write data; ddr_busy in 1 DDR not-accepting.
REQ-008 SHALL have ports: busy out 1 clearing active; sd_done out 1; ddr_done out 1; done out 1 full clear completed.

Function
REQ-009 SHALL implement states IDLE, CLEAR, DONE.
REQ-010 IDLE or DONE with start=1 SHALL enter CLEAR next cycle, zeroing sd_addr, ddr_addr, gap counter, sd_done, ddr_done, done.
REQ-011 start SHALL be ignored in CLEAR.
REQ-012 busy SHALL be 1 exactly while in CLEAR; done SHALL be 1 exactly while in DONE.
REQ-013 SDRAM engine: in CLEAR, sd_done=0, gap counter 0 -> sd_we=1 for one cycle at current sd_addr; gap counter loads WE_GAP-1, decrements each cycle.
REQ-014 sd_addr SHALL increment the cycle after each strobe; strobe at SD_WORDS-1 sets sd_done next cycle, sd_addr then holds.
REQ-015 First sd_we SHALL occur in the first CLEAR cycle; strobes spaced exactly WE_GAP cycles.
REQ-016 DDR engine: in CLEAR, ddr_done=0 -> ddr_we=1; write accepted at edge with ddr_we=1 and ddr_busy=0.
REQ-017 ddr_addr and ddr_din SHALL stay stable while ddr_we=1 and not accepted.
REQ-018 After acceptance ddr_addr SHALL increment with ddr_we kept high (one write per cycle when ddr_busy=0); acceptance at DDR_WORDS-1 drops ddr_we and sets ddr_done next cycle.
REQ-019 Engines SHALL run concurrently and independently; CLEAR SHALL go to DONE the cycle after both sd_done and ddr_done are 1.
REQ-020 abort=1 in CLEAR SHALL set an internal abort flag and suppress further sd_we strobes that same cycle onward.
REQ-021 With abort flag set, a pending DDR request SHALL be held until accepted, then ddr_we dropped; state SHALL enter IDLE the cycle after no DDR request is outstanding; done stays 0.
REQ-022 abort in IDLE or DONE SHALL be ignored; start and abort together in IDLE SHALL start (abort ignored).
REQ-023 Address arithmetic SHALL be unsigned and never exceed SD_WORDS-1 / DDR_WORDS-1 (no wrap).

Reset
REQ-024 RESET=0 at a clk_sys edge SHALL force IDLE and all outputs, addresses, counters, flags to 0, including mid-CLEAR with a DDR request pending.
REQ-025 After RESET returns to 1, no write SHALL be issued until start.

Configuration
REQ-026 Macro RAM_CLEAR_PATTERN_EN defined: sd_din = sd_addr[15:0], ddr_din = {36'd0, ddr_addr} (address-as-data fill).
REQ-027 Macro undefined: sd_din = 0 and ddr_din = 0 constantly (zero fill); no other behaviour differs.

Verification (SD_WORDS=4, DDR_WORDS=3, WE_GAP=4)
REQ-028 start pulse, ddr_busy=0 -> ddr_we high 3 cycles addr 0,1,2; sd_we at CLEAR cycles 0,4,8,12 addr 0..3; done=1 at cycle 14, busy=0.
REQ-029 ddr_busy=1 for first 10 CLEAR cycles -> ddr_addr=0, ddr_we=1 stable throughout; SDRAM strobes unaffected; addr 1 presented cycle 11.
REQ-030 abort at CLEAR cycle 2 with ddr_busy=1 until cycle 6 -> no sd_we after cycle 0, ddr_we drops after cycle-6 acceptance, IDLE cycle 7, done=0.
REQ-031 RESET=0 at CLEAR cycle 5 -> next cycle all outputs 0, state IDLE; subsequent start clears from address 0.
REQ-032 start in DONE -> done=0, busy=1 next cycle, full sequence repeats from address 0.
REQ-033 With RAM_CLEAR_PATTERN_EN: sd_din=2 at sd_addr 2, ddr_din=1 at ddr_addr 1; without: both 0.

Source files
------------

// File: rtl/ram_clear_ctrl.sv
// Clears an SDRAM (strobe-paced) and a DDR3 (handshaked) memory concurrently.
// Define RAM_CLEAR_PATTERN_EN for address-as-data fill; default build writes zeros.
//
// state | meaning
// IDLE  | waiting for start, no writes issued
// CLEAR | both write engines running
// DONE  | both memories fully written
module ram_clear_ctrl #(
    parameter int SD_WORDS  = 33554432,
    parameter int DDR_WORDS = 268435456,
    parameter int WE_GAP    = 32
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        start,
    input  logic        abort,
    output logic        sd_we,
    output logic [24:0] sd_addr,
    output logic [15:0] sd_din,
    output logic        ddr_we,
    output logic [27:0] ddr_addr,
    output logic [63:0] ddr_din,
    input  logic        ddr_busy,
    output logic        busy,
    output logic        sd_done,
    output logic        ddr_done,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    localparam logic [24:0] SD_LAST  = 25'(SD_WORDS - 1);
    localparam logic [27:0] DDR_LAST = 28'(DDR_WORDS - 1);
    localparam logic [7:0]  GAP_LOAD = 8'(WE_GAP - 1);

    state_t      state_q, state_d;
    logic [24:0] sd_addr_q, sd_addr_d;
    logic [27:0] ddr_addr_q, ddr_addr_d;
    logic [7:0]  gap_q, gap_d;
    logic        sd_done_q, sd_done_d;
    logic        ddr_done_q, ddr_done_d;
    logic        abort_q, abort_d;
    logic        abort_now;
    logic        ddr_acc;

    always_comb begin
        state_d    = state_q;
        sd_addr_d  = sd_addr_q;
        ddr_addr_d = ddr_addr_q;
        gap_d      = gap_q;
        sd_done_d  = sd_done_q;
        ddr_done_d = ddr_done_q;
        abort_d    = abort_q;

        // abort takes effect in the very cycle it is raised
        abort_now = (state_q == CLEAR) && (abort || abort_q);
        sd_we     = (state_q == CLEAR) && !sd_done_q && (gap_q == 8'd0) && !abort_now;
        ddr_we    = (state_q == CLEAR) && !ddr_done_q;
        ddr_acc   = ddr_we && !ddr_busy;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = CLEAR;
                    sd_addr_d  = '0;
                    ddr_addr_d = '0;
                    gap_d      = '0;
                    sd_done_d  = 1'b0;
                    ddr_done_d = 1'b0;
                    abort_d    = 1'b0;
                end
            end
            CLEAR: begin
                if (abort) abort_d = 1'b1;

                if (sd_we) begin
                    gap_d = GAP_LOAD;
                    if (sd_addr_q == SD_LAST) sd_done_d = 1'b1;
                    else                      sd_addr_d = sd_addr_q + 25'd1;
                end else if (gap_q != 8'd0) begin
                    gap_d = gap_q - 8'd1;
                end

                if (ddr_acc) begin
                    if (ddr_addr_q == DDR_LAST) ddr_done_d = 1'b1;
                    else                        ddr_addr_d = ddr_addr_q + 28'd1;
                end

                // an outstanding DDR request must complete before leaving
                if (abort_now) begin
                    if (!ddr_we || ddr_acc) state_d = IDLE;
                end else if (sd_done_q && ddr_done_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!RESET) begin
            state_q    <= IDLE;
            sd_addr_q  <= '0;
            ddr_addr_q <= '0;
            gap_q      <= '0;
            sd_done_q  <= 1'b0;
            ddr_done_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sd_addr_q  <= sd_addr_d;
            ddr_addr_q <= ddr_addr_d;
            gap_q      <= gap_d;
            sd_done_q  <= sd_done_d;
            ddr_done_q <= ddr_done_d;
            abort_q    <= abort_d;
        end
    end

    assign sd_addr  = sd_addr_q;
    assign ddr_addr = ddr_addr_q;
    assign sd_done  = sd_done_q;
    assign ddr_done = ddr_done_q;
    assign busy     = (state_q == CLEAR);
    assign done     = (state_q == DONE);

`ifdef RAM_CLEAR_PATTERN_EN
    assign sd_din  = sd_addr_q[15:0];
    assign ddr_din = {36'd0, ddr_addr_q};
`else
    assign sd_din  = 16'd0;
    assign ddr_din = 64'd0;
`endif

endmodule

// File: tb/tb_ram_clear_ctrl.sv
// Bench for ram_clear_ctrl: directed scenarios plus random start/abort/busy/reset
// traffic, every cycle compared against a word-count based reference model.
module tb_ram_clear_ctrl;

    localparam int SD  = 4;
    localparam int DDR = 3;
    localparam int GAP = 4;

    logic        clk_sys = 1'b0;
    logic        RESET   = 1'b0;
    logic        start   = 1'b0;
    logic        abort   = 1'b0;
    logic        ddr_busy = 1'b0;
    logic        sd_we, ddr_we, busy, sd_done, ddr_done, done;
    logic [24:0] sd_addr;
    logic [15:0] sd_din;
    logic [27:0] ddr_addr;
    logic [63:0] ddr_din;

    ram_clear_ctrl #(.SD_WORDS(SD), .DDR_WORDS(DDR), .WE_GAP(GAP)) dut (
        .clk_sys(clk_sys), .RESET(RESET), .start(start), .abort(abort),
        .sd_we(sd_we), .sd_addr(sd_addr), .sd_din(sd_din),
        .ddr_we(ddr_we), .ddr_addr(ddr_addr), .ddr_din(ddr_din), .ddr_busy(ddr_busy),
        .busy(busy), .sd_done(sd_done), .ddr_done(ddr_done), .done(done)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: mode 0 idle, 1 clearing, 2 done; progress held as word counts
    int m_mode = 0;
    int m_sd_cnt = 0;
    int m_ddr_cnt = 0;
    int m_since = 0;
    bit m_abort = 0;

    task automatic step(input logic st, input logic ab, input logic bz, input logic rs);
        bit e_clear, e_sd_done, e_ddr_done, e_abort, e_sd_we, e_ddr_we, acc;
        int e_sd_addr, e_ddr_addr;
        logic [63:0] e_sd_din, e_ddr_din;
        @(negedge clk_sys);
        start = st; abort = ab; ddr_busy = bz; RESET = rs;
        #1;
        e_clear    = (m_mode == 1);
        e_sd_done  = (m_sd_cnt == SD);
        e_ddr_done = (m_ddr_cnt == DDR);
        e_abort    = e_clear && (m_abort || ab);
        e_sd_we    = e_clear && !e_sd_done && (m_since >= GAP) && !e_abort;
        e_ddr_we   = e_clear && !e_ddr_done;
        e_sd_addr  = (m_sd_cnt < SD) ? m_sd_cnt : SD - 1;
        e_ddr_addr = (m_ddr_cnt < DDR) ? m_ddr_cnt : DDR - 1;
`ifdef RAM_CLEAR_PATTERN_EN
        e_sd_din  = 64'(e_sd_addr);
        e_ddr_din = 64'(e_ddr_addr);
`else
        e_sd_din  = 64'd0;
        e_ddr_din = 64'd0;
`endif
        chk("sd_we",    64'(sd_we),    64'(e_sd_we));
        chk("sd_addr",  64'(sd_addr),  64'(e_sd_addr));
        chk("sd_din",   64'(sd_din),   e_sd_din);
        chk("ddr_we",   64'(ddr_we),   64'(e_ddr_we));
        chk("ddr_addr", 64'(ddr_addr), 64'(e_ddr_addr));
        chk("ddr_din",  ddr_din,       e_ddr_din);
        chk("busy",     64'(busy),     64'(e_clear));
        chk("sd_done",  64'(sd_done),  64'(e_sd_done));
        chk("ddr_done", 64'(ddr_done), 64'(e_ddr_done));
        chk("done",     64'(done),     64'(m_mode == 2));

        acc = e_ddr_we && !bz;
        if (!rs) begin
            m_mode = 0; m_sd_cnt = 0; m_ddr_cnt = 0; m_since = 0; m_abort = 0;
        end else if (m_mode != 1) begin
            if (st) begin
                m_mode = 1; m_sd_cnt = 0; m_ddr_cnt = 0; m_since = GAP; m_abort = 0;
            end
        end else begin
            if (ab) m_abort = 1;
            if (e_sd_we) begin
                m_sd_cnt++;
                m_since = 1;
            end else if (m_since < GAP) begin
                m_since++;
            end
            if (acc) m_ddr_cnt++;
            if (e_abort && (!e_ddr_we || acc)) m_mode = 0;
            else if (e_sd_done && e_ddr_done) m_mode = 2;
        end
    endtask

    int first_done, first_idle, first_a1, n_sd, n_ddr, n_done;

    initial begin
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 1, 0, 1);

        // plain clear, no back-pressure
        step(1, 0, 0, 1);
        first_done = -1; n_sd = 0; n_ddr = 0;
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 0, 1);
            if (sd_we) n_sd++;
            if (ddr_we) n_ddr++;
            if (done && first_done < 0) first_done = k;
        end
        chk("done_cycle", 64'(first_done), 64'd14);
        chk("sd_strobes", 64'(n_sd), 64'd4);
        chk("ddr_writes", 64'(n_ddr), 64'd3);

        // restart from DONE with DDR held busy for 10 cycles
        step(1, 0, 0, 1);
        first_a1 = -1;
        for (int k = 0; k < 20; k++) begin
            step(0, 0, (k < 10), 1);
            if (ddr_addr == 28'd1 && first_a1 < 0) first_a1 = k;
        end
        chk("ddr_addr1_cycle", 64'(first_a1), 64'd11);

        // abort at cycle 2 with DDR busy until cycle 6
        step(1, 0, 0, 1);
        first_idle = -1; n_sd = 0; n_done = 0;
        for (int k = 0; k < 12; k++) begin
            step(0, (k == 2), (k < 6), 1);
            if (sd_we) n_sd++;
            if (done) n_done++;
            if (!busy && first_idle < 0) first_idle = k;
        end
        chk("abort_idle_cycle", 64'(first_idle), 64'd7);
        chk("abort_sd_strobes", 64'(n_sd), 64'd1);
        chk("abort_done", 64'(n_done), 64'd0);

        // reset in the middle of a clear, then clear again
        step(1, 0, 0, 1);
        for (int k = 0; k < 8; k++) step(0, 0, (k < 7), (k != 5));
        step(1, 0, 0, 1);
        for (int k = 0; k < 18; k++) step(0, 0, 0, 1);

        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 199) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
